// File: rtl/wb_cmd_bridge_pkg.sv
// Shared definitions for the UART-to-Wishbone command bridge: state encoding,
// command byte layout and the default response codes.
package wb_cmd_bridge_pkg;

  // Bridge state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_DATA = 2'd1;
  localparam logic [1:0] ST_BUS      = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Command byte field positions
  localparam int CMD_WE_BIT  = 7;
  localparam int CMD_RSVD_HI = 6;
  localparam int CMD_RSVD_LO = 4;
  localparam int CMD_ADR_HI  = 3;
  localparam int CMD_ADR_LO  = 0;

  // Default response codes
  localparam logic [7:0] DEF_ACK_BYTE    = 8'hAA;
  localparam logic [7:0] DEF_ERR_TIMEOUT = 8'hEE;
  localparam logic [7:0] DEF_ERR_CMD     = 8'hE1;

  // Width of the bus timeout counter (covers the full 1..65535 range)
  localparam int TIMEOUT_W = 16;

  typedef struct packed {
    logic       we;
    logic [2:0] rsvd;
    logic [3:0] adr;
  } cmd_t;

  // Split a raw command byte into its fields
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c.we   = b[CMD_WE_BIT];
    c.rsvd = b[CMD_RSVD_HI:CMD_RSVD_LO];
    c.adr  = b[CMD_ADR_HI:CMD_ADR_LO];
    return c;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Loadable up-counter with clear and enable. expired_o flags the cycle whose
// increment brings the count up to limit_i, so a master can abort on the same
// edge the limit is reached.
module wb_timeout_ctr #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;

  // Count register: clear beats load, load beats increment
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= count_q + ONE;
    end
  end

  assign expired_o = en_i && (count_q >= (limit_i - ONE));

endmodule

// File: rtl/wb_cmd_bridge.sv
// Turns host command bytes from the UART receiver into single Wishbone
// transactions and returns one response byte (read data, write ack or an
// error code) to the UART transmitter.
module wb_cmd_bridge
  import wb_cmd_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] ERR_TIMEOUT    = DEF_ERR_TIMEOUT,
  parameter logic [7:0] ERR_CMD        = DEF_ERR_CMD
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [3:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  output logic       busy_o,
  output logic       overrun_o
);

  logic [1:0] state_q;
  cmd_t       rx_cmd;
  logic       timeout_hit;

  assign rx_cmd = decode_cmd(rx_data_i);

  // Strobe and response-valid come straight from the state register, so a
  // reset drops them immediately without waiting for a clock edge.
  assign wb_stb_o   = (state_q == ST_BUS);
  assign wb_cyc_o   = wb_stb_o;
  assign tx_valid_o = (state_q == ST_RESP);
  assign busy_o     = (state_q != ST_IDLE);

  // Counts no-ack cycles while the strobe is out; held at zero elsewhere
  wb_timeout_ctr #(
    .W (TIMEOUT_W)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (state_q != ST_BUS),
    .en_i       ((state_q == ST_BUS) && !wb_ack_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .limit_i    (TIMEOUT_W'(TIMEOUT_CYCLES)),
    .expired_o  (timeout_hit)
  );

  // Command sequencing: decode, optional data byte, one bus cycle, one response
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      tx_data_o <= '0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid_i) begin
            if (rx_cmd.rsvd != 3'b000) begin
              tx_data_o <= ERR_CMD;
              state_q   <= ST_RESP;
            end else begin
              wb_adr_o <= rx_cmd.adr;
              wb_we_o  <= rx_cmd.we;
              state_q  <= rx_cmd.we ? ST_GET_DATA : ST_BUS;
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_valid_i) begin
            wb_dat_o <= rx_data_i;
            state_q  <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            tx_data_o <= wb_we_o ? ACK_BYTE : wb_dat_i;
            state_q   <= ST_RESP;
          end else if (timeout_hit) begin
            tx_data_o <= ERR_TIMEOUT;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky flag for bytes dropped while a transaction or response is pending
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overrun_o <= 1'b0;
    end else if (rx_valid_i && ((state_q == ST_BUS) || (state_q == ST_RESP))) begin
      overrun_o <= 1'b1;
    end
  end

endmodule
